// File: rtl/cache_types_pkg.sv
// Shared types and constants for the direct-mapped cache controller.
package cache_types_pkg;

   localparam int NUM_SETS = 8;
   localparam int INDEX_W  = $clog2(NUM_SETS);
   localparam int CNT_W    = 16;

   // Data store write source
   localparam logic DATA_SRC_PMEM = 1'b0;
   localparam logic DATA_SRC_CPU  = 1'b1;

   // Physical memory address source
   localparam logic PMEM_ADDR_CPU = 1'b0;
   localparam logic PMEM_ADDR_WB  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } cache_state_t;

endpackage

// File: rtl/cache_control_if.sv
// Control bundle between the cache controller, the CPU/datapath and physical memory.
interface cache_control_if;

   logic mem_read;
   logic mem_write;
   logic mem_resp;
   logic hit;
   logic valid;
   logic dirty;
   logic pmem_read;
   logic pmem_write;
   logic pmem_resp;
   logic valid_load;
   logic tag_load;
   logic data_load;
   logic dirty_load;
   logic dirty_in;
   logic data_src_sel;
   logic pmem_addr_sel;

   // Controller side
   modport master (
      input  mem_read, mem_write, hit, valid, dirty, pmem_resp,
      output mem_resp, pmem_read, pmem_write,
      output valid_load, tag_load, data_load, dirty_load, dirty_in,
      output data_src_sel, pmem_addr_sel
   );

   // CPU / datapath / memory side
   modport slave (
      output mem_read, mem_write, hit, valid, dirty, pmem_resp,
      input  mem_resp, pmem_read, pmem_write,
      input  valid_load, tag_load, data_load, dirty_load, dirty_in,
      input  data_src_sel, pmem_addr_sel
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = cache_types_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_reg;

   // Clear has priority; increment stops once the counter is full
   always_ff @(posedge clk) begin
      if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != CNT_MAX)) begin
         count_reg <= count_reg + CNT_ONE;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/cache_control.sv
// Direct-mapped cache controller: IDLE / WRITEBACK / ALLOCATE FSM plus
// hit, miss and writeback performance counters.
module cache_control #(
   parameter int NUM_SETS = cache_types_pkg::NUM_SETS,
   parameter int CNT_W    = cache_types_pkg::CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   cache_control_if.master         bus,
   output logic [CNT_W-1:0]        hit_count,
   output logic [CNT_W-1:0]        miss_count,
   output logic [CNT_W-1:0]        wb_count
);

   import cache_types_pkg::*;

   // The valid/dirty/tag stores are sized from the package; refuse a mismatch
   if ((NUM_SETS != cache_types_pkg::NUM_SETS) || (NUM_SETS != (1 << INDEX_W))) begin : g_sets_check
      $error("cache_control: NUM_SETS does not match the store geometry");
   end

   cache_state_t state_reg;
   cache_state_t state_next;
   logic         refill_reg;
   logic         req;
   logic [2:0]   cnt_inc;
   logic [CNT_W-1:0] cnt_val [3];

   // A simultaneous read and write is serviced as a write
   assign req = bus.mem_read | bus.mem_write;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Refill flag: the IDLE cycle right after a refill is the replayed miss, not a hit
   always_ff @(posedge clk) begin
      if (rst) begin
         refill_reg <= 1'b0;
      end else if ((state_reg == ST_ALLOCATE) && bus.pmem_resp) begin
         refill_reg <= 1'b1;
      end else if (state_reg == ST_IDLE) begin
         refill_reg <= 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req && !bus.hit) begin
               state_next = (bus.valid && bus.dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            if (bus.pmem_resp) state_next = ST_ALLOCATE;
         end
         ST_ALLOCATE: begin
            if (bus.pmem_resp) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode; every output idles low
   always_comb begin
      bus.mem_resp      = 1'b0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      bus.valid_load    = 1'b0;
      bus.tag_load      = 1'b0;
      bus.data_load     = 1'b0;
      bus.dirty_load    = 1'b0;
      bus.dirty_in      = 1'b0;
      bus.data_src_sel  = DATA_SRC_PMEM;
      bus.pmem_addr_sel = PMEM_ADDR_CPU;
      case (state_reg)
         ST_IDLE: begin
            if (bus.mem_write && bus.hit) begin
               bus.data_load    = 1'b1;
               bus.data_src_sel = DATA_SRC_CPU;
               bus.dirty_load   = 1'b1;
               bus.dirty_in     = 1'b1;
               bus.mem_resp     = 1'b1;
            end else if (bus.mem_read && bus.hit) begin
               bus.mem_resp = 1'b1;
            end
         end
         ST_WRITEBACK: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = PMEM_ADDR_WB;
         end
         ST_ALLOCATE: begin
            bus.pmem_read     = 1'b1;
            bus.pmem_addr_sel = PMEM_ADDR_CPU;
            if (bus.pmem_resp) begin
               bus.data_load    = 1'b1;
               bus.tag_load     = 1'b1;
               bus.valid_load   = 1'b1;
               bus.dirty_load   = 1'b1;
               bus.data_src_sel = DATA_SRC_PMEM;
               bus.dirty_in     = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Counter increment strobes: [0] hit, [1] miss, [2] writeback
   always_comb begin
      cnt_inc    = 3'b000;
      cnt_inc[0] = (state_reg == ST_IDLE) && req && bus.hit && !refill_reg;
      cnt_inc[1] = (state_reg == ST_IDLE) && req && !bus.hit;
      cnt_inc[2] = (state_reg == ST_WRITEBACK) && bus.pmem_resp;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .clr   (rst),
         .inc   (cnt_inc[gi]),
         .count (cnt_val[gi])
      );
   end

   assign hit_count  = cnt_val[0];
   assign miss_count = cnt_val[1];
   assign wb_count   = cnt_val[2];

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cache_control;

   logic clk = 1'b0;
   logic rst;
   logic [15:0] hit_count, miss_count, wb_count;
   logic [3:0]  s_hit, s_miss, s_wb;

   int checks   = 0;
   int failures = 0;

   // kind: 0 = mem_resp, 1 = writeback completes, 2 = refill completes
   typedef struct {
      int          kind;
      logic        wr;
      logic [15:0] hc;
      logic [15:0] mc;
      logic [15:0] wc;
   } exp_t;
   exp_t exp_q[$];

   cache_control_if bus();
   cache_control_if sat_bus();

   cache_control #(.NUM_SETS(8), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .wb_count   (wb_count)
   );

   cache_control #(.NUM_SETS(8), .CNT_W(4)) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .bus        (sat_bus),
      .hit_count  (s_hit),
      .miss_count (s_miss),
      .wb_count   (s_wb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic wr, input logic [15:0] hc,
                       input logic [15:0] mc, input logic [15:0] wc);
      exp_t e;
      e.kind = kind; e.wr = wr; e.hc = hc; e.mc = mc; e.wc = wc;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one line per observed transaction
   always @(negedge clk) begin : mon
      exp_t e;
      int   kind;
      if (rst === 1'b0) begin
         check("pmem_exclusive", {31'd0, bus.pmem_read & bus.pmem_write}, 32'd0);
         kind = -1;
         if (bus.mem_resp) kind = 0;
         else if (bus.pmem_resp && bus.pmem_write) kind = 1;
         else if (bus.pmem_resp && bus.pmem_read) kind = 2;
         if (kind >= 0) begin
            $display("t=%0t event kind=%0d hc=%0d mc=%0d wc=%0d", $time, kind,
                     hit_count, miss_count, wb_count);
            if (exp_q.size() == 0) begin
               check("unexpected_event", kind, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", kind, e.kind);
               if (e.kind == 0 && kind == 0) begin
                  check("resp_data_load", {31'd0, bus.data_load}, {31'd0, e.wr});
                  check("resp_dirty_in", {31'd0, bus.dirty_in}, {31'd0, e.wr});
                  check("resp_dirty_load", {31'd0, bus.dirty_load}, {31'd0, e.wr});
                  check("resp_src_sel", {31'd0, bus.data_src_sel}, {31'd0, e.wr});
                  check("resp_hit_count", hit_count, e.hc);
                  check("resp_miss_count", miss_count, e.mc);
                  check("resp_wb_count", wb_count, e.wc);
               end else if (e.kind == 1 && kind == 1) begin
                  check("wb_addr_sel", {31'd0, bus.pmem_addr_sel}, 32'd1);
               end else if (e.kind == 2 && kind == 2) begin
                  check("fill_addr_sel", {31'd0, bus.pmem_addr_sel}, 32'd0);
                  check("fill_loads", {28'd0, bus.valid_load, bus.tag_load,
                                       bus.data_load, bus.dirty_load}, 32'hF);
                  check("fill_src_sel", {31'd0, bus.data_src_sel}, 32'd0);
                  check("fill_dirty_in", {31'd0, bus.dirty_in}, 32'd0);
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.valid = 0;
      bus.dirty = 0; bus.pmem_resp = 0;
      sat_bus.mem_read = 0; sat_bus.mem_write = 0; sat_bus.hit = 0; sat_bus.valid = 0;
      sat_bus.dirty = 0; sat_bus.pmem_resp = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_mem_resp", {31'd0, bus.mem_resp}, 0);
      check("rst_pmem_rw", {30'd0, bus.pmem_read, bus.pmem_write}, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
      check("rst_wb_count", wb_count, 0);
      tick();

      // Read hit, zero latency
      bus.mem_read = 1; bus.hit = 1;
      push(0, 0, 0, 0, 0);
      tick();
      bus.mem_read = 0; bus.hit = 0;
      @(negedge clk);
      check("rdhit_hit_count", hit_count, 1);
      check("rdhit_miss_count", miss_count, 0);
      tick();

      // Clean read miss, 5-cycle refill
      bus.mem_read = 1; bus.hit = 0; bus.valid = 0; bus.dirty = 0;
      push(2, 0, 0, 0, 0);
      push(0, 0, 1, 1, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.pmem_resp = (i == 4);
         @(negedge clk);
         check("clean_pmem_read", {31'd0, bus.pmem_read}, 1);
         check("clean_no_pmem_write", {31'd0, bus.pmem_write}, 0);
         tick();
      end
      bus.pmem_resp = 0; bus.hit = 1;
      tick();
      bus.mem_read = 0; bus.hit = 0;
      @(negedge clk);
      check("clean_hit_count", hit_count, 1);
      check("clean_miss_count", miss_count, 1);
      tick();

      // Dirty write miss: writeback, refill, then write hit
      bus.mem_write = 1; bus.hit = 0; bus.valid = 1; bus.dirty = 1;
      push(1, 0, 0, 0, 0);
      push(2, 0, 0, 0, 0);
      push(0, 1, 1, 2, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.pmem_resp = (i == 2);
         @(negedge clk);
         check("dirty_pmem_write", {31'd0, bus.pmem_write}, 1);
         check("dirty_wb_addr", {31'd0, bus.pmem_addr_sel}, 1);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         bus.pmem_resp = (i == 1);
         @(negedge clk);
         check("dirty_pmem_read", {31'd0, bus.pmem_read}, 1);
         tick();
      end
      bus.pmem_resp = 0; bus.hit = 1; bus.dirty = 0;
      tick();
      bus.mem_write = 0; bus.hit = 0; bus.valid = 0;
      @(negedge clk);
      check("dirty_wb_count", wb_count, 1);
      check("dirty_miss_count", miss_count, 2);
      check("dirty_hit_count", hit_count, 1);
      tick();

      // Read and write together behave as a write hit
      bus.mem_read = 1; bus.mem_write = 1; bus.hit = 1;
      push(0, 1, 1, 2, 1);
      tick();
      bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0;
      @(negedge clk);
      check("rw_hit_count", hit_count, 2);
      tick();

      // Request dropped during refill: pmem_read holds, no mem_resp
      bus.mem_read = 1; bus.hit = 0; bus.valid = 0;
      push(2, 0, 0, 0, 0);
      tick();
      bus.mem_read = 0;
      for (int i = 0; i < 3; i++) begin
         bus.pmem_resp = (i == 2);
         @(negedge clk);
         check("abort_pmem_read", {31'd0, bus.pmem_read}, 1);
         tick();
      end
      bus.pmem_resp = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("abort_no_resp", {31'd0, bus.mem_resp}, 0);
         tick();
      end
      @(negedge clk);
      check("abort_miss_count", miss_count, 3);
      check("abort_hit_count", hit_count, 2);
      tick();

      // Reset in the middle of a writeback
      bus.mem_write = 1; bus.hit = 0; bus.valid = 1; bus.dirty = 1;
      tick();
      @(negedge clk);
      check("wbrst_pmem_write_before", {31'd0, bus.pmem_write}, 1);
      check("wbrst_miss_before", miss_count, 4);
      tick();
      rst = 1;
      tick();
      rst = 0; bus.mem_write = 0; bus.valid = 0; bus.dirty = 0;
      @(negedge clk);
      check("wbrst_pmem_write_after", {31'd0, bus.pmem_write}, 0);
      check("wbrst_pmem_read_after", {31'd0, bus.pmem_read}, 0);
      check("wbrst_counters", {hit_count, miss_count | wb_count}, 0);
      check("wbrst_all_outputs", {22'd0, bus.mem_resp, bus.valid_load, bus.tag_load,
                                  bus.data_load, bus.dirty_load, bus.dirty_in,
                                  bus.data_src_sel, bus.pmem_addr_sel,
                                  bus.pmem_read, bus.pmem_write}, 0);
      tick();

      // Saturation with 4-bit counters
      sat_bus.mem_read = 1; sat_bus.hit = 1;
      repeat (10) tick();
      @(negedge clk);
      check("sat_hit_10", s_hit, 10);
      repeat (10) tick();
      @(negedge clk);
      check("sat_hit_held", s_hit, 15);
      check("sat_miss", s_miss, 0);
      sat_bus.mem_read = 0; sat_bus.hit = 0;
      tick();
      tick();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameter NUM_SETS, 8, number of direct-mapped sets; must match the valid/dirty/tag stores.
REQ-002 Parameter CNT_W, 16, width of each performance counter.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 mem_read  in  1  CPU read request, held until mem_resp.
REQ-006 mem_write  in  1  CPU write request, held until mem_resp.
REQ-007 mem_resp  out  1  CPU request complete, single-cycle pulse.
REQ-008 hit  in  1  tag match AND valid for the indexed line, from datapath.
REQ-009 valid  in  1  valid_out of the valid store for the indexed line.
REQ-010 dirty  in  1  dirty bit of the indexed line.
REQ-011 pmem_read / pmem_write  out  1 each  physical memory line read / write request.
REQ-012 pmem_resp  in  1  physical memory transaction complete.
REQ-013 valid_load, tag_load, data_load, dirty_load, dirty_in  out  1 each  store write enables; dirty_in is the dirty value written.
REQ-014 data_src_sel  out  1  0 = line from pmem, 1 = CPU write merge.
REQ-015 pmem_addr_sel  out  1  0 = CPU address, 1 = {stored tag, index} writeback address.
REQ-016 hit_count, miss_count, wb_count  out  CNT_W each  performance counters.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WRITEBACK, ALLOCATE; all outputs except counters are combinational from state and inputs, and each is 0 unless set below.
REQ-018 IDLE, no request: remain in IDLE.
REQ-019 IDLE, read hit: mem_resp=1 in the same cycle (zero-cycle latency); remain in IDLE.
REQ-020 IDLE, write hit: data_load=1, data_src_sel=1, dirty_load=1, dirty_in=1, mem_resp=1 in the same cycle; remain in IDLE.
REQ-021 IDLE, miss with valid=1 and dirty=1: go to WRITEBACK; miss with valid=0 or dirty=0: go to ALLOCATE.
REQ-022 WRITEBACK: pmem_write=1, pmem_addr_sel=1; on pmem_resp=1 go to ALLOCATE and increment wb_count.
REQ-023 ALLOCATE: pmem_read=1, pmem_addr_sel=0; on pmem_resp=1 assert data_load, tag_load, valid_load, dirty_load with data_src_sel=0, dirty_in=0; go to IDLE.
REQ-024 After ALLOCATE, IDLE re-evaluates the held request, which SHALL hit and complete per REQ-019/020 (clean-miss mem_resp one cycle after pmem_resp).
REQ-025 miss_count SHALL increment once per miss, on the IDLE->WRITEBACK or IDLE->ALLOCATE transition.
REQ-026 A refill flag SHALL be set on ALLOCATE completion and cleared on the next IDLE cycle; hit_count increments on an IDLE hit only when the flag is clear.
REQ-027 Counters SHALL saturate at all-ones, with no wrap.
REQ-028 mem_read and mem_write both high: treat as write.
REQ-029 Request dropped during WRITEBACK/ALLOCATE: the in-flight pmem transaction SHALL complete (no abort); the controller then returns to IDLE and asserts no mem_resp.
REQ-030 pmem_read and pmem_write SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 at a posedge: state=IDLE, refill flag=0, all counters=0; this overrides any in-flight transaction, so pmem_read/pmem_write are 0 from the following cycle.
REQ-032 After reset with no request, every output SHALL be 0.

Structure
REQ-033 Shared package cache_types_pkg SHALL hold the cache_state_t enum, NUM_SETS, index width, CNT_W and the select encodings.
REQ-034 One sub-module, sat_counter (CNT_W-bit, synchronous clear and increment enable), SHALL be instantiated three times.

Verification
REQ-035 Read hit in IDLE: mem_read=1, hit=1 -> mem_resp=1 same cycle, hit_count 0->1, miss_count=0.
REQ-036 Clean miss: mem_read=1, hit=0, valid=0; pmem_resp after 5 cycles; hit=1 thereafter -> ALLOCATE for 5 cycles, valid_load=1 on the pmem_resp cycle, mem_resp next cycle, miss_count=1, hit_count=0.
REQ-037 Dirty miss write: mem_write=1, hit=0, valid=1, dirty=1 -> WRITEBACK (pmem_addr_sel=1) then ALLOCATE then write hit with dirty_in=1; wb_count=1, miss_count=1.
REQ-038 Reset mid-WRITEBACK: rst pulsed for 1 cycle -> pmem_write=0 the next cycle, state IDLE, all counters 0.
REQ-039 Saturation: CNT_W forced to 4, 20 read hits -> hit_count holds at 15.
REQ-040 Abort attempt: mem_read dropped in ALLOCATE -> pmem_read stays high until pmem_resp, no mem_resp issued.
